// File: rtl/loop_outer_ctrl_if.sv
// loop_outer_ctrl_if: run handshake and inner-counter control bundle for the outer-loop controller
interface loop_outer_ctrl_if #(parameter int NI = 3);
  logic start, abort, inner_done;
  logic [NI-1:0] i;
  logic inner_en, inner_clr, busy, done;
  modport master (output start, abort, inner_done, input i, inner_en, inner_clr, busy, done);
  modport slave (input start, abort, inner_done, output i, inner_en, inner_clr, busy, done);
endinterface

// File: rtl/loop_outer_ctrl.sv
// loop_outer_ctrl: outer-loop sequencer stepping i from N-1 down to 1, restarting the inner counter each pass
module loop_outer_ctrl #(
  parameter int N = 8,
  parameter int NI = 3
) (
  input logic clk,
  input logic reset,
  loop_outer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, RUN, STEP, FIN} state_t;
  state_t state, nxt;
  logic [NI-1:0] i_q, i_nxt;
  logic en_q, clr_q, busy_q, done_q;
  logic last;
  assign last = i_q == NI'(1);
  always_comb begin
    nxt = state;
    i_nxt = i_q;
    case (state)
      IDLE: begin
        nxt = bus.start ? CLR : IDLE;
        i_nxt = bus.start ? NI'(N - 1) : i_q;
      end
      CLR: nxt = bus.abort ? IDLE : RUN;
      RUN: nxt = bus.abort ? IDLE : bus.inner_done ? STEP : RUN;
      STEP: begin
        nxt = bus.abort ? IDLE : last ? FIN : CLR;
        i_nxt = (bus.abort || last) ? i_q : i_q - NI'(1);
      end
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered copies of the state decode, so they switch with the state itself
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      i_q <= '0;
      en_q <= 1'b0;
      clr_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      i_q <= i_nxt;
      en_q <= nxt == RUN;
      clr_q <= nxt == CLR;
      busy_q <= nxt != IDLE;
      done_q <= nxt == FIN;
    end
  end
  assign bus.i = i_q;
  assign bus.inner_en = en_q;
  assign bus.inner_clr = clr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_loop_outer_ctrl.sv
// tb_loop_outer_ctrl: table-driven scoreboard bench for loop_outer_ctrl at N=4, N=2 and N=8
module tb_loop_outer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, inner_done = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  loop_outer_ctrl_if #(.NI(3)) b4 ();
  loop_outer_ctrl_if #(.NI(2)) b2 ();
  loop_outer_ctrl_if #(.NI(3)) b8 ();
  assign b4.start = start;
  assign b4.abort = abort;
  assign b4.inner_done = inner_done;
  assign b2.start = start;
  assign b2.abort = abort;
  assign b2.inner_done = inner_done;
  assign b8.start = start;
  assign b8.abort = abort;
  assign b8.inner_done = inner_done;

  loop_outer_ctrl #(.N(4), .NI(3)) d4 (.clk(clk), .reset(reset), .bus(b4));
  loop_outer_ctrl #(.N(2), .NI(2)) d2 (.clk(clk), .reset(reset), .bus(b2));
  loop_outer_ctrl #(.N(8), .NI(3)) d8 (.clk(clk), .reset(reset), .bus(b8));

  typedef struct {
    logic s, a, d;
    int i;
    logic en, clr, busy, done;
  } vec_t;
  vec_t tbl [26];
  vec_t q [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // called at a falling edge: drive, queue the expectation, pop it after the next rising edge
  task automatic apply(input vec_t v, input int n);
    vec_t e;
    start = v.s;
    abort = v.a;
    inner_done = v.d;
    q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    chk($sformatf("vec%0d i", n), int'(b4.i), e.i);
    chk($sformatf("vec%0d en/clr/busy/done", n), int'({b4.inner_en, b4.inner_clr, b4.busy, b4.done}),
        int'({e.en, e.clr, e.busy, e.done}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    inner_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [2:0] pd;
  task automatic mon(input string n, input logic en, input logic clr, input logic busy, input logic done,
                     input logic prev);
    tests++;
    if ((en && clr) || (prev && done) || (!busy && (en || clr || done))) begin
      fails++;
      $display("FAIL monitor %s: en=%b clr=%b busy=%b done=%b prev_done=%b", n, en, clr, busy, done, prev);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) pd <= 3'b000;
    else begin
      mon("n4", b4.inner_en, b4.inner_clr, b4.busy, b4.done, pd[0]);
      mon("n2", b2.inner_en, b2.inner_clr, b2.busy, b2.done, pd[1]);
      mon("n8", b8.inner_en, b8.inner_clr, b8.busy, b8.done, pd[2]);
      pd <= {b8.done, b2.done, b4.done};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_n, en_n, done_n, run, runs, bad_runs;
    logic [9:0] eb, ec, ed;
    tbl = '{
      '{1,0,1, 3,0,1,1,0}, '{0,0,1, 3,1,0,1,0}, '{0,0,1, 3,0,0,1,0}, '{0,0,1, 2,0,1,1,0},
      '{1,0,1, 2,1,0,1,0}, '{0,0,1, 2,0,0,1,0}, '{0,0,1, 1,0,1,1,0}, '{0,0,1, 1,1,0,1,0},
      '{0,0,1, 1,0,0,1,0}, '{0,0,1, 1,0,0,1,1}, '{1,1,1, 1,0,0,0,0}, '{0,1,0, 1,0,0,0,0},
      '{1,0,1, 3,0,1,1,0}, '{0,0,1, 3,1,0,1,0}, '{0,0,1, 3,0,0,1,0}, '{0,0,0, 2,0,1,1,0},
      '{0,0,0, 2,1,0,1,0}, '{0,0,0, 2,1,0,1,0}, '{0,1,1, 2,0,0,0,0}, '{0,0,1, 2,0,0,0,0},
      '{1,0,1, 3,0,1,1,0}, '{0,1,1, 3,0,0,0,0}, '{1,0,1, 3,0,1,1,0}, '{0,0,1, 3,1,0,1,0},
      '{0,0,1, 3,0,0,1,0}, '{0,1,1, 3,0,0,0,0}
    };
    @(negedge clk);
    chk("reset i", int'(b4.i), 0);
    chk("reset flags", int'({b4.inner_en, b4.inner_clr, b4.busy, b4.done}), 0);
    reset = 1'b1;
    for (int k = 0; k < 26; k++) apply(tbl[k], k + 1);

    // start present across reset release is honoured on the first edge
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    cyc();
    chk("post-release start i", int'(b4.i), 3);
    chk("post-release start flags", int'({b4.inner_en, b4.inner_clr, b4.busy, b4.done}), 4'b0110);

    // inner_done asserted on the sixth RUN cycle of every pass
    do_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    clr_n = 0; en_n = 0; done_n = 0; run = 0; runs = 0; bad_runs = 0;
    for (int c = 0; c < 40; c++) begin
      clr_n += int'(b4.inner_clr);
      done_n += int'(b4.done);
      if (b4.inner_en) begin
        run++;
        en_n++;
      end else if (run != 0) begin
        runs++;
        if (run != 6) bad_runs++;
        run = 0;
      end
      inner_done = b4.inner_en && run == 6;
      cyc();
    end
    chk("slow inner clr pulses", clr_n, 3);
    chk("slow inner en cycles", en_n, 18);
    chk("slow inner runs", runs, 3);
    chk("slow inner runs not 6 long", bad_runs, 0);
    chk("slow inner done pulses", done_n, 1);
    chk("slow inner idle at end", int'(b4.busy), 0);

    // N=2 with start held: one IDLE cycle between runs
    do_reset();
    start = 1'b1;
    inner_done = 1'b1;
    eb = 10'b0111101111;
    ec = 10'b0000100001;
    ed = 10'b0100001000;
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk($sformatf("n2 cycle%0d busy/clr/done", c + 1), int'({b2.busy, b2.inner_clr, b2.done}),
          int'({eb[c], ec[c], ed[c]}));
      if (b2.inner_clr) chk($sformatf("n2 cycle%0d i", c + 1), int'(b2.i), 1);
    end

    // N=8 asynchronous reset mid-RUN at i=5
    do_reset();
    start = 1'b1;
    inner_done = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    chk("n8 pre-reset i", int'(b8.i), 5);
    chk("n8 pre-reset en", int'(b8.inner_en), 1);
    #2 reset = 1'b0;
    #1;
    chk("n8 async reset i", int'(b8.i), 0);
    chk("n8 async reset flags", int'({b8.inner_en, b8.inner_clr, b8.busy, b8.done}), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("n8 idle after reset %0d", c), int'({b8.i, b8.busy, b8.done}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
